// File: rtl/mojo_com_regbridge.sv
// mojo_com_regbridge: UART command bridge into a flat byte-addressed register space
// Optional feature macro: COM_ACK_EN (echo the header byte back after each completed write)
// Ports:
//   clk, rst                         clock, async active-high reset
//   ser_rx_data, ser_new_rx_data     received UART byte + strobe
//   ser_tx_data, ser_new_tx_data     byte to UART transmitter + strobe
//   ser_tx_busy                      UART transmitter busy
//   rx_arr, rx_busy, new_rx          host-written image, write in progress, write done pulse
//   tx_arr, tx_busy                  host-readable image, read in progress
//   err                              inter-byte timeout abort pulse
module mojo_com_regbridge #(
  parameter int DEPTH          = 256,
  parameter int ADDR_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           ser_rx_data,
  input  logic                 ser_new_rx_data,
  output logic [7:0]           ser_tx_data,
  output logic                 ser_new_tx_data,
  input  logic                 ser_tx_busy,
  output logic [8*DEPTH-1:0]   rx_arr,
  output logic                 rx_busy,
  output logic                 new_rx,
  input  logic [8*DEPTH-1:0]   tx_arr,
  output logic                 tx_busy,
  output logic                 err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RDATA, S_RWAIT
`ifdef COM_ACK_EN
    , S_ACK, S_AHOLD
`endif
  } state_t;
  state_t             r_state, w_next;
  logic               r_dir, r_ab, r_new_tx, r_new_rx, r_err;
  logic [6:0]         r_cnt;
  logic [AW-1:0]      r_addr;
  logic [TW-1:0]      r_tmo;
  logic [7:0]         r_tx_data;
  logic [8*DEPTH-1:0] r_rx_arr;
  logic               w_hdr, w_abyte, w_wr, w_send, w_last, w_cnt_en, w_tmo, w_rx_state;
  logic [AW+7:0]      w_shift;
`ifdef COM_ACK_EN
  logic [7:0]         r_hdr;
  logic               w_ack;
  assign w_rx_state = r_state == S_ADDR || r_state == S_WDATA || r_state == S_ACK || r_state == S_AHOLD;
`else
  assign w_rx_state = r_state == S_ADDR || r_state == S_WDATA;
`endif
  assign w_last   = r_cnt == 7'd1;
  assign w_cnt_en = r_state == S_ADDR || r_state == S_WDATA;
  assign w_tmo    = w_cnt_en && r_tmo == TW'(TIMEOUT_CYCLES - 1);
  // shifting the full byte in and truncating gives the modulo-DEPTH address
  assign w_shift  = {r_addr, ser_rx_data};
  assign rx_busy         = r_dir && w_rx_state;
  assign tx_busy         = !r_dir && (r_state == S_ADDR || r_state == S_RDATA || r_state == S_RWAIT);
  assign rx_arr          = r_rx_arr;
  assign new_rx          = r_new_rx;
  assign err             = r_err;
  assign ser_tx_data     = r_tx_data;
  assign ser_new_tx_data = r_new_tx;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next  = r_state;
    w_hdr   = 1'b0;
    w_abyte = 1'b0;
    w_wr    = 1'b0;
    w_send  = 1'b0;
`ifdef COM_ACK_EN
    w_ack   = 1'b0;
`endif
    case (r_state)
      S_IDLE:
        if (ser_new_rx_data && ser_rx_data[6:0] != 7'd0) begin
          w_hdr  = 1'b1;
          w_next = S_ADDR;
        end
      S_ADDR:
        if (w_tmo) w_next = S_IDLE;
        else if (ser_new_rx_data) begin
          w_abyte = 1'b1;
          if (r_ab == 1'(ADDR_BYTES - 1)) w_next = r_dir ? S_WDATA : S_RDATA;
        end
      S_WDATA:
        if (w_tmo) w_next = S_IDLE;
        else if (ser_new_rx_data) begin
          w_wr = 1'b1;
`ifdef COM_ACK_EN
          if (w_last) w_next = S_ACK;
`else
          if (w_last) w_next = S_IDLE;
`endif
        end
      S_RDATA:
        if (!ser_tx_busy) begin
          w_send = 1'b1;
          w_next = w_last ? S_IDLE : S_RWAIT;
        end
      // transmitter raises busy one cycle after our strobe; skip that cycle
      S_RWAIT: w_next = S_RDATA;
`ifdef COM_ACK_EN
      S_ACK:
        if (!ser_tx_busy) begin
          w_ack  = 1'b1;
          w_next = S_AHOLD;
        end
      S_AHOLD: w_next = S_IDLE;
`endif
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dir     <= 1'b0;
      r_ab      <= 1'b0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_tmo     <= '0;
      r_tx_data <= '0;
      r_new_tx  <= 1'b0;
      r_new_rx  <= 1'b0;
      r_err     <= 1'b0;
      r_rx_arr  <= '0;
`ifdef COM_ACK_EN
      r_hdr     <= '0;
`endif
    end else begin
      r_new_tx <= 1'b0;
      r_new_rx <= w_wr && w_last;
      r_err    <= w_tmo;
      r_tmo    <= (!w_cnt_en || w_abyte || w_wr) ? '0 : r_tmo + 1'b1;
      if (w_hdr) begin
        r_dir  <= ser_rx_data[7];
        r_cnt  <= ser_rx_data[6:0];
        r_addr <= '0;
        r_ab   <= 1'b0;
`ifdef COM_ACK_EN
        r_hdr  <= ser_rx_data;
`endif
      end
      if (w_abyte) begin
        r_addr <= w_shift[AW-1:0];
        r_ab   <= r_ab + 1'b1;
      end
      if (w_wr) r_rx_arr[{r_addr, 3'b000} +: 8] <= ser_rx_data;
      if (w_wr || w_send) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_send) begin
        r_tx_data <= tx_arr[{r_addr, 3'b000} +: 8];
        r_new_tx  <= 1'b1;
      end
`ifdef COM_ACK_EN
      if (w_ack) begin
        r_tx_data <= r_hdr;
        r_new_tx  <= 1'b1;
      end
`endif
    end
endmodule

// File: tb/tb_mojo_com_regbridge.sv
// tb_mojo_com_regbridge: directed self-checking bench for mojo_com_regbridge
module tb_mojo_com_regbridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0]       rxd0 = '0, rxd1 = '0, txd0, txd1;
  logic             stb0 = 1'b0, stb1 = 1'b0, txb0 = 1'b0;
  logic             ntx0, ntx1, rxb0, rxb1, nrx0, nrx1, txbz0, txbz1, err0, err1;
  logic [8*256-1:0]  txa0 = '0, rxa0;
  logic [8*1024-1:0] txa1 = '0, rxa1;
  int n_tests = 0, n_fail = 0, n_new = 0, n_err = 0, n_tx = 0, n_bad = 0;
  logic [7:0] txq[$];
  mojo_com_regbridge #(.DEPTH(256), .ADDR_BYTES(1), .TIMEOUT_CYCLES(50)) u0 (
    .clk(clk), .rst(rst), .ser_rx_data(rxd0), .ser_new_rx_data(stb0),
    .ser_tx_data(txd0), .ser_new_tx_data(ntx0), .ser_tx_busy(txb0),
    .rx_arr(rxa0), .rx_busy(rxb0), .new_rx(nrx0), .tx_arr(txa0),
    .tx_busy(txbz0), .err(err0)
  );
  mojo_com_regbridge #(.DEPTH(1024), .ADDR_BYTES(2), .TIMEOUT_CYCLES(50)) u1 (
    .clk(clk), .rst(rst), .ser_rx_data(rxd1), .ser_new_rx_data(stb1),
    .ser_tx_data(txd1), .ser_new_tx_data(ntx1), .ser_tx_busy(1'b0),
    .rx_arr(rxa1), .rx_busy(rxb1), .new_rx(nrx1), .tx_arr(txa1),
    .tx_busy(txbz1), .err(err1)
  );
  always @(negedge clk) begin
    if (nrx0) n_new++;
    if (err0) n_err++;
    if (ntx0) begin
      n_tx++;
      txq.push_back(txd0);
      if (txb0) n_bad++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit d, input logic [7:0] b);
    if (d) begin rxd1 = b; stb1 = 1'b1; end
    else   begin rxd0 = b; stb0 = 1'b1; end
    tick();
    stb0 = 1'b0;
    stb1 = 1'b0;
    tick();
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    int base_new, base_err, base_tx, e, k;
    tick();
    tick();
    check("rst_rx_arr", 64'(|rxa0), 0);
    check("rst_outs", {rxb0, txbz0, nrx0, err0, ntx0, txd0}, 0);
    rst = 1'b0;
    tick();
    base_new = n_new;
    base_tx  = n_tx;
    send(0, 8'h80);
    check("len0_idle", {rxb0, txbz0}, 0);
    send(0, 8'h81);
    check("wr_busy_rise", rxb0, 1);
    send(0, 8'h02);
    send(0, 8'h06);
    repeat (4) tick();
    send(0, 8'h82);
    send(0, 8'h00);
    send(0, 8'hAD);
    send(0, 8'hDE);
    repeat (4) tick();
    check("wr_data", rxa0[23:0], 24'h06DEAD);
    check("wr_new_rx_count", n_new - base_new, 2);
    check("wr_busy_low", rxb0, 0);
`ifdef COM_ACK_EN
    check("ack_count", n_tx - base_tx, 2);
    check("ack_byte0", txq[0], 8'h81);
    check("ack_byte1", txq[1], 8'h82);
`else
    check("wr_no_tx", n_tx - base_tx, 0);
`endif
    txa0[31:0] = 32'hDEADBEEF;
    base_tx = n_tx;
    send(0, 8'h03);
    check("rd_busy_rise", txbz0, 1);
    send(0, 8'h01);
    k = 0;
    while (n_tx == base_tx && k < 20) begin tick(); k++; end
    txb0 = 1'b1;
    repeat (10) tick();
    check("rd_hold_while_busy", n_tx - base_tx, 1);
    txb0 = 1'b0;
    k = 0;
    while ((n_tx - base_tx < 3 || txbz0) && k < 40) begin tick(); k++; end
    check("rd_count", n_tx - base_tx, 3);
    check("rd_b0", txq[base_tx], 8'hBE);
    check("rd_b1", txq[base_tx+1], 8'hAD);
    check("rd_b2", txq[base_tx+2], 8'hDE);
    check("rd_no_strobe_busy", n_bad, 0);
    check("rd_busy_low", txbz0, 0);
    repeat (2) tick();
    check("rd_tx_hold", txd0, 8'hDE);
    send(0, 8'h82);
    send(0, 8'hFF);
    send(0, 8'h11);
    send(0, 8'h22);
    repeat (4) tick();
    check("wrap_hi", rxa0[2047:2040], 8'h11);
    check("wrap_lo", rxa0[7:0], 8'h22);
    base_new = n_new;
    base_err = n_err;
    send(0, 8'h83);
    send(0, 8'h00);
    send(0, 8'h55);
    e = 1;
    while (!err0 && e < 100) begin tick(); e++; end
    check("tmo_cycles", e, 50);
    check("tmo_busy_clr", rxb0, 0);
    tick();
    check("tmo_err_width", err0, 0);
    check("tmo_err_count", n_err - base_err, 1);
    check("tmo_kept_byte", rxa0[7:0], 8'h55);
    check("tmo_no_new_rx", n_new - base_new, 0);
    send(0, 8'h81);
    send(0, 8'h01);
    send(0, 8'h77);
    repeat (4) tick();
    check("post_tmo_data", rxa0[15:8], 8'h77);
    check("post_tmo_new_rx", n_new - base_new, 1);
    send(1, 8'h81);
    send(1, 8'h05);
    send(1, 8'h10);
    send(1, 8'h99);
    repeat (4) tick();
    check("a2_mod_addr", rxa1[8*272 +: 8], 8'h99);
    check("a2_busy_low", rxb1, 0);
    send(0, 8'h84);
    send(0, 8'h00);
    send(0, 8'h01);
    send(0, 8'h02);
    check("mid_busy", rxb0, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_arr", 64'(|rxa0), 0);
    check("mid_rst_flags", {rxb0, txbz0, nrx0, err0}, 0);
    rst = 1'b0;
    tick();
    base_tx = n_tx;
    send(0, 8'h81);
    send(0, 8'h00);
    send(0, 8'h5A);
    repeat (4) tick();
    check("post_rst_data", rxa0[7:0], 8'h5A);
`ifdef COM_ACK_EN
    check("ack_post_rst_count", n_tx - base_tx, 1);
    check("ack_post_rst_byte", txq[txq.size()-1], 8'h81);
`else
    check("post_rst_no_tx", n_tx - base_tx, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mojo_com_regbridge.md
Name: mojo_com_regbridge

Overview:
- Parametrised successor to the serial command bridge between the Mojo UART (ser_* handshake) and a flat byte-addressed register space.
- Host sends a header byte, ADDR_BYTES address bytes, then data bytes for writes; for reads the block streams bytes from tx_arr back over the UART.
- Adds over the previous generation: configurable depth and address width, modulo address wrap, inter-byte timeout with error pulse, and an optional write acknowledge.

Parameters:
- DEPTH, 256, register space size in bytes; power of two, 2..65536.
- ADDR_BYTES, 1, number of address bytes after the header, big-endian; 1 or 2.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes inside a command before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- ser_rx_data  in  8  received UART byte.
- ser_new_rx_data  in  1  one-cycle strobe qualifying ser_rx_data.
- ser_tx_data  out  8  byte to UART transmitter.
- ser_new_tx_data  out  1  one-cycle strobe qualifying ser_tx_data.
- ser_tx_busy  in  1  UART transmitter busy.
- rx_arr  out  8*DEPTH  host-written register image; byte a is rx_arr[8a+7:8a].
- rx_busy  out  1  write command in progress.
- new_rx  out  1  one-cycle pulse when a write command completes.
- tx_arr  in  8*DEPTH  register image readable by the host.
- tx_busy  out  1  read command in progress.
- err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset: all outputs 0, rx_arr all-zero, state IDLE, counters 0. Reset mid-command aborts immediately; no partial output persists.
- Header byte: bit7 = 1 for write, 0 for read; bits[6:0] = length in bytes (1..127). A length of 0 is consumed and ignored; the block stays in IDLE.
- IDLE -> ADDR on a header strobe. Latch dir and len. rx_busy (write) or tx_busy (read) rises the next cycle.
- ADDR: collects ADDR_BYTES bytes, MSB first. The address is taken modulo DEPTH (upper bits dropped).
- Then WDATA for a write, or RDATA for a read.
- WDATA: each strobe writes the byte to rx_arr[8*addr +: 8] on that edge.
  - Address then increments modulo DEPTH; wrap from DEPTH-1 to 0 is legal.
  - After the len-th byte: new_rx pulses for 1 cycle the following cycle, rx_busy falls, return to IDLE (or ACK under the macro).
- RDATA:
  - When ser_tx_busy = 0, drive ser_tx_data = tx_arr[8*addr +: 8] and pulse ser_new_tx_data for 1 cycle.
  - Go to RWAIT for exactly 1 cycle, since the transmitter raises busy one cycle late, then return to RDATA.
  - After the len-th byte is sent: tx_busy falls, return to IDLE. Address wraps as in WDATA.
- ser_new_rx_data during RDATA/RWAIT (or ACK) is ignored and the byte is dropped.
- ser_tx_data holds its last value between strobes.
- Timeout counter:
  - Resets on every accepted rx byte.
  - Counts in ADDR and WDATA only.
  - On reaching TIMEOUT_CYCLES: pulse err 1 cycle, clear busy flags, return to IDLE.
  - Bytes already written stay written; new_rx is not pulsed.
- An rx strobe in the same cycle as timeout expiry: timeout wins and the byte is dropped.
- No back-to-back strobe assumption: consecutive ser_new_rx_data pulses one cycle apart must be accepted.

Optional Feature:
- Macro COM_ACK_EN.
- Defined: after a write completes, enter ACK. Wait for ser_tx_busy = 0, send one byte equal to the latched header byte, then hold 1 cycle and return to IDLE. rx_busy stays high through ACK; new_rx pulses on ACK entry.
- Undefined: no ACK state; no tx activity on writes.

Test Plan:
- DEPTH=256: send 0x81,0x02,0x06 then 0x82,0x00,0xAD,0xDE -> rx_arr[23:0] = 24'h06DEAD; new_rx pulses exactly twice; rx_busy low afterward.
- tx_arr[31:0] = 32'hDEADBEEF; send 0x03,0x01; hold ser_tx_busy high 10 cycles after the first strobe -> ser_tx_data sequence BE,AD,DE; no strobe while busy; tx_busy falls after the third.
- Wrap: send 0x82,0xFF,0x11,0x22 -> rx_arr[2047:2040] = 0x11, rx_arr[7:0] = 0x22.
- Timeout with TIMEOUT_CYCLES=50: send 0x83,0x00,0x55 then idle -> err pulses 50 cycles after 0x55, rx_arr[7:0] = 0x55, no new_rx, next 0x81,0x01,0x77 works normally.
- ADDR_BYTES=2, DEPTH=1024: send 0x81,0x05,0x10,0x99 -> address 0x510 mod 1024 = 0x110; rx_arr[8*272 +: 8] = 0x99.
- Assert rst during WDATA of a 4-byte write after 2 bytes -> rx_arr all-zero, busy flags 0, IDLE; with COM_ACK_EN, a completed 0x81 write returns byte 0x81.
